// File: rtl/ahblite_uart_slave.sv
// AHB-Lite UART responder: zero-wait register interface, TX FIFO feeding an 8N1
// serializer, 8N1 deserializer behind a 2-flop synchronizer, programmable baud divider.
module ahblite_uart_slave #(
   parameter int          TX_FIFO_DEPTH = 4,
   parameter logic [15:0] BAUDDIV_RESET = 16'd434
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic        TXD,
   input  logic        RXD
);
   localparam int AW = $clog2(TX_FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(TX_FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} uart_state_t;

   logic        wr_en_r, rd_en_r;
   logic [1:0]  addr_r;
   logic [15:0] bauddiv_r;
   logic [7:0]  fifo_mem_r [TX_FIFO_DEPTH];
   logic [AW-1:0] wptr_r, rptr_r;
   logic [AW:0] count_r;
   uart_state_t tx_state_r, tx_state_nxt;
   logic [15:0] tx_cnt_r;
   logic [2:0]  tx_bit_r;
   logic [7:0]  tx_shift_r;
   logic        txd_r, tx_pop_s, tx_tick_s;
   uart_state_t rx_state_r, rx_state_nxt;
   logic        rx_meta_r, rx_sync_r, rx_prev_r;
   logic [15:0] rx_cnt_r;
   logic [2:0]  rx_bit_r;
   logic [7:0]  rx_shift_r, rx_data_r;
   logic        rx_valid_r, overrun_r, frame_err_r;
   logic        rx_tick_s, rx_fall_s, rx_done_s, rx_ferr_s;
   logic [31:0] hrdata_s;

   wire unused_s = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

   wire wr_data_s    = wr_en_r && (addr_r == 2'd0);
   wire wr_stat_s    = wr_en_r && (addr_r == 2'd1);
   wire wr_baud_s    = wr_en_r && (addr_r == 2'd2);
   wire rd_data_s    = rd_en_r && (addr_r == 2'd0);
   wire fifo_empty_s = (count_r == '0);
   wire fifo_full_s  = (count_r == FULL_CNT);
   wire push_s       = wr_data_s && !fifo_full_s;
   wire tx_empty_s   = fifo_empty_s && (tx_state_r == ST_IDLE);
   wire [15:0] reload_s = bauddiv_r - 16'd1;

   // Address phase capture into the data phase
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_en_r <= 1'b0;
         rd_en_r <= 1'b0;
         addr_r  <= 2'd0;
      end else if (HSEL && HTRANS[1] && HREADY) begin
         wr_en_r <= HWRITE;
         rd_en_r <= !HWRITE;
         addr_r  <= HADDR[3:2];
      end else begin
         wr_en_r <= 1'b0;
         rd_en_r <= 1'b0;
      end
   end

   // Baud divider register, clamped so every bit lasts at least 4 cycles
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         bauddiv_r <= BAUDDIV_RESET;
      else if (wr_baud_s)
         bauddiv_r <= (HWDATA[15:0] < 16'd4) ? 16'd4 : HWDATA[15:0];
      else
         bauddiv_r <= bauddiv_r;
   end

   // TX FIFO storage and pointers; full is judged before a same-cycle pop
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < TX_FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'd0;
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wptr_r] <= HWDATA[7:0];
            wptr_r <= wptr_r + AW'(1);
         end
         if (tx_pop_s) rptr_r <= rptr_r + AW'(1);
         case ({push_s, tx_pop_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1);
            2'b01:   count_r <= count_r - (AW + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // TX next-state logic
   always_comb begin
      tx_state_nxt = tx_state_r;
      tx_pop_s     = 1'b0;
      tx_tick_s    = (tx_cnt_r == 16'd0);
      case (tx_state_r)
         ST_IDLE: begin
            tx_pop_s     = !fifo_empty_s;
            tx_state_nxt = fifo_empty_s ? ST_IDLE : ST_START;
         end
         ST_START: tx_state_nxt = tx_tick_s ? ST_DATA : ST_START;
         ST_DATA:  tx_state_nxt = (tx_tick_s && tx_bit_r == 3'd7) ? ST_STOP : ST_DATA;
         ST_STOP:  tx_state_nxt = tx_tick_s ? ST_IDLE : ST_STOP;
         default:  tx_state_nxt = ST_IDLE;
      endcase
   end

   // TX state register and serializer datapath
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= 16'd0;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'd0;
         txd_r      <= 1'b1;
      end else begin
         tx_state_r <= tx_state_nxt;
         case (tx_state_r)
            ST_IDLE: begin
               txd_r <= !tx_pop_s;
               if (tx_pop_s) begin
                  tx_shift_r <= fifo_mem_r[rptr_r];
                  tx_cnt_r   <= reload_s;
                  tx_bit_r   <= 3'd0;
               end
            end
            ST_START, ST_DATA: begin
               if (tx_tick_s) begin
                  tx_cnt_r   <= reload_s;
                  txd_r      <= (tx_state_r == ST_DATA && tx_bit_r == 3'd7) ? 1'b1 : tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  if (tx_state_r == ST_DATA) tx_bit_r <= tx_bit_r + 3'd1;
               end else begin
                  tx_cnt_r <= tx_cnt_r - 16'd1;
               end
            end
            ST_STOP: if (!tx_tick_s) tx_cnt_r <= tx_cnt_r - 16'd1;
            default: txd_r <= 1'b1;
         endcase
      end
   end

   // RX next-state logic; the start bit is re-checked near its centre to reject glitches
   always_comb begin
      rx_state_nxt = rx_state_r;
      rx_tick_s    = (rx_cnt_r == 16'd0);
      rx_fall_s    = rx_prev_r && !rx_sync_r;
      rx_done_s    = 1'b0;
      rx_ferr_s    = 1'b0;
      case (rx_state_r)
         ST_IDLE:  rx_state_nxt = rx_fall_s ? ST_START : ST_IDLE;
         ST_START: rx_state_nxt = !rx_tick_s ? ST_START : (rx_sync_r ? ST_IDLE : ST_DATA);
         ST_DATA:  rx_state_nxt = (rx_tick_s && rx_bit_r == 3'd7) ? ST_STOP : ST_DATA;
         ST_STOP: begin
            rx_state_nxt = rx_tick_s ? ST_IDLE : ST_STOP;
            rx_done_s    = rx_tick_s && rx_sync_r;
            rx_ferr_s    = rx_tick_s && !rx_sync_r;
         end
         default:  rx_state_nxt = ST_IDLE;
      endcase
   end

   // RX synchronizer, state register and deserializer datapath
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_meta_r  <= 1'b1;
         rx_sync_r  <= 1'b1;
         rx_prev_r  <= 1'b1;
         rx_state_r <= ST_IDLE;
         rx_cnt_r   <= 16'd0;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'd0;
      end else begin
         rx_meta_r  <= RXD;
         rx_sync_r  <= rx_meta_r;
         rx_prev_r  <= rx_sync_r;
         rx_state_r <= rx_state_nxt;
         case (rx_state_r)
            ST_IDLE: begin
               rx_cnt_r <= {1'b0, bauddiv_r[15:1]};
               rx_bit_r <= 3'd0;
            end
            ST_START, ST_STOP: rx_cnt_r <= rx_tick_s ? reload_s : rx_cnt_r - 16'd1;
            ST_DATA: begin
               if (rx_tick_s) begin
                  rx_cnt_r   <= reload_s;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  rx_bit_r   <= rx_bit_r + 3'd1;
               end else begin
                  rx_cnt_r <= rx_cnt_r - 16'd1;
               end
            end
            default: rx_cnt_r <= 16'd0;
         endcase
      end
   end

   // RX status flags; a DATA read in the completion cycle sees the old byte without overrun
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_data_r   <= 8'd0;
         rx_valid_r  <= 1'b0;
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (rx_done_s) rx_data_r <= rx_shift_r;
         if (rx_done_s)      rx_valid_r <= 1'b1;
         else if (rd_data_s) rx_valid_r <= 1'b0;
         if (rx_done_s && rx_valid_r && !rd_data_s) overrun_r <= 1'b1;
         else if (wr_stat_s)                         overrun_r <= 1'b0;
         if (rx_ferr_s)      frame_err_r <= 1'b1;
         else if (wr_stat_s) frame_err_r <= 1'b0;
      end
   end

   // Read data mux, driven only during a read data phase
   always_comb begin
      hrdata_s = 32'd0;
      if (rd_en_r) begin
         case (addr_r)
            2'd0:    hrdata_s = {24'd0, rx_data_r};
            2'd1:    hrdata_s = {27'd0, frame_err_r, overrun_r, rx_valid_r, tx_empty_s, fifo_full_s};
            2'd2:    hrdata_s = {16'd0, bauddiv_r};
            default: hrdata_s = 32'd0;
         endcase
      end else begin
         hrdata_s = 32'd0;
      end
   end

   assign HRDATA    = hrdata_s;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign TXD       = txd_r;
endmodule

// File: tb/tb_ahblite_uart_slave.sv
// Scoreboard bench for ahblite_uart_slave: read data and TX frames are checked
// against expectations queued when the stimulus is issued.
module tb_ahblite_uart_slave;
   localparam int DEPTH = 4;

   logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
   logic [31:0] HADDR = 32'd0, HWDATA = 32'd0;
   logic [1:0]  HTRANS = 2'd0;
   logic [2:0]  HSIZE = 3'd2;
   logic        rxd_drv = 1'b1, loop_en = 1'b0;
   wire         HREADYOUT, HRESP, TXD;
   wire  [31:0] HRDATA;
   wire         RXD = loop_en ? TXD : rxd_drv;

   ahblite_uart_slave #(.TX_FIFO_DEPTH(DEPTH), .BAUDDIV_RESET(16'd434)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .TXD(TXD), .RXD(RXD));

   always #5 HCLK = ~HCLK;

   int errors = 0, checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Read scoreboard
   logic [31:0] rd_exp_q[$];
   string       rd_tag_q[$];
   logic        rd_dphase = 1'b0;

   always @(posedge HCLK) rd_dphase <= HSEL && HTRANS[1] && !HWRITE && HREADY;

   always @(negedge HCLK) begin
      if (rd_dphase && rd_exp_q.size() > 0) check_eq(rd_tag_q.pop_front(), HRDATA, rd_exp_q.pop_front());
   end

   // TX frame monitor: every cycle of every bit must hold the bit's level
   logic [7:0] tx_exp_q[$];
   int   mon_baud = 434, mon_bit = 0, mon_cyc = 0, tx_frames = 0;
   bit   mon_en = 1'b1, mon_busy = 1'b0, mon_ok = 1'b0;
   logic [9:0] mon_frame = 10'd0;

   task automatic mon_finish();
      logic [7:0] e;
      if (tx_exp_q.size() == 0) begin
         check_eq("tx_unexpected_frame", 32'(tx_exp_q.size()), 32'd1);
      end else begin
         e = tx_exp_q.pop_front();
         check_eq("tx_frame", 32'({mon_ok, mon_frame}), 32'({1'b1, 1'b1, e, 1'b0}));
      end
   endtask

   always @(negedge HCLK) begin
      if (!HRESETn || !mon_en) begin
         mon_busy <= 1'b0;
      end else if (!mon_busy) begin
         if (TXD === 1'b0) begin
            mon_busy  <= 1'b1;
            mon_bit   <= 0;
            mon_cyc   <= 1;
            mon_ok    <= 1'b1;
            mon_frame <= 10'd0;
         end
      end else if (mon_cyc == mon_baud) begin
         if (mon_bit == 9) begin
            mon_finish();
            mon_busy  <= 1'b0;
            tx_frames <= tx_frames + 1;
         end else begin
            mon_frame[mon_bit + 1] <= TXD;
            mon_bit <= mon_bit + 1;
            mon_cyc <= 1;
         end
      end else begin
         if (TXD !== mon_frame[mon_bit]) mon_ok <= 1'b0;
         mon_cyc <= mon_cyc + 1;
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      rd_exp_q.push_back(exp);
      rd_tag_q.push_back(tag);
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
   endtask

   task automatic tx_send(input logic [7:0] b);
      tx_exp_q.push_back(b);
      bus_write(32'h0, {24'd0, b});
   endtask

   task automatic wait_tx_drain(input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (tx_exp_q.size() == 0 && !mon_busy) break;
         @(posedge HCLK);
      end
      check_eq(tag, 32'(tx_exp_q.size()) + 32'(mon_busy), 32'd0);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge HCLK); #1;
         rxd_drv = bits[i];
         repeat (7) @(posedge HCLK);
      end
      @(posedge HCLK); #1;
      rxd_drv = 1'b1;
      repeat (6) @(posedge HCLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int frames0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check_eq("rst_txd", 32'(TXD), 32'd1);
      check_eq("rst_hrdata", HRDATA, 32'd0);
      check_eq("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      check_eq("rst_hresp", 32'(HRESP), 32'd0);
      HRESETn = 1'b1;

      bus_read(32'h8, 32'h0000_01B2, "bauddiv_rst");
      bus_read(32'h4, 32'h0000_0002, "status_rst");
      bus_read(32'hC, 32'h0000_0000, "reserved_rd");
      bus_write(32'h8, 32'h0000_0002);
      bus_read(32'h8, 32'h0000_0004, "bauddiv_min");

      // single transmit
      bus_write(32'h8, 32'd8);
      mon_baud = 8;
      tx_send(8'hA5);
      bus_read(32'h4, 32'h0, "tx_busy_start");
      repeat (60) @(posedge HCLK);
      bus_read(32'h4, 32'h0, "tx_busy_mid");
      wait_tx_drain(200, "tx_single_drain");
      bus_read(32'h4, 32'h2, "tx_empty_done");

      // FIFO full with back-to-back pipelined writes
      bus_write(32'h8, 32'd4);
      mon_baud = 4;
      frames0 = tx_frames;
      for (int i = 0; i < 6; i++) begin
         @(posedge HCLK); #1;
         HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
         if (i > 0) HWDATA = 32'h10 + 32'(i);
         if (i < DEPTH + 1) tx_exp_q.push_back(8'h11 + 8'(i));
      end
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h16;
      bus_read(32'h4, 32'h1, "tx_full");
      wait_tx_drain(500, "tx_burst_drain");
      check_eq("tx_burst_frames", 32'(tx_frames - frames0), 32'd5);

      // RX loopback
      bus_write(32'h8, 32'd8);
      mon_baud = 8;
      loop_en = 1'b1;
      tx_send(8'h3C);
      repeat (100) @(posedge HCLK);
      bus_read(32'h4, 32'h6, "rx_valid_set");
      bus_read(32'h0, 32'h3C, "rx_data_3c");
      bus_read(32'h4, 32'h2, "rx_valid_clr");
      tx_send(8'h01);
      tx_send(8'h02);
      wait_tx_drain(400, "tx_loop_drain");
      repeat (10) @(posedge HCLK);
      bus_read(32'h4, 32'hE, "overrun_set");
      bus_read(32'h0, 32'h02, "rx_overwrite");
      bus_write(32'h4, 32'h0);
      bus_read(32'h4, 32'h2, "overrun_clr");

      // RX glitch and framing error
      loop_en = 1'b0;
      repeat (5) @(posedge HCLK);
      #1 rxd_drv = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 rxd_drv = 1'b1;
      repeat (30) @(posedge HCLK);
      bus_read(32'h4, 32'h2, "rx_glitch");
      rx_frame(8'h5A, 1'b0);
      bus_read(32'h4, 32'h12, "frame_err");
      rx_frame(8'h96, 1'b1);
      bus_read(32'h4, 32'h16, "rx_after_ferr");
      bus_read(32'h0, 32'h96, "rx_data_96");
      bus_write(32'h4, 32'h0);
      bus_read(32'h4, 32'h2, "ferr_clr");

      // reset during TX data bit 3
      mon_en = 1'b0;
      tx_exp_q.delete();
      bus_write(32'h0, 32'h00);
      bus_write(32'h0, 32'h55);
      for (int i = 0; i < 100; i++) begin
         @(negedge HCLK);
         if (TXD === 1'b0) break;
      end
      check_eq("tx_start_seen", 32'(TXD), 32'd0);
      repeat (35) @(negedge HCLK);
      check_eq("tx_bit3_low", 32'(TXD), 32'd0);
      #2 HRESETn = 1'b0;
      #1 check_eq("txd_async_rst", 32'(TXD), 32'd1);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      bus_read(32'h4, 32'h2, "status_after_rst");
      bus_read(32'h8, 32'h1B2, "baud_after_rst");
      repeat (20) @(negedge HCLK);
      check_eq("tx_idle_after_rst", 32'(TXD), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
